// File: rtl/axis_tx_arbiter_if.sv
// AXI-Stream bundle between N_SRC traffic sources, the TX arbiter and the
// converter's s_axis port.
// The master modport is the environment: it drives the source streams and the
// converter ready. The slave modport is the arbiter.
interface axis_tx_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DWIDTH = 512
);
    logic [N_SRC*DWIDTH-1:0]     s_axis_tdata;
    logic [N_SRC*(DWIDTH/8)-1:0] s_axis_tkeep;
    logic [N_SRC-1:0]            s_axis_tlast;
    logic [N_SRC-1:0]            s_axis_tvalid;
    logic [N_SRC-1:0]            s_axis_tready;

    logic [DWIDTH-1:0]           m_axis_tdata;
    logic [DWIDTH/8-1:0]         m_axis_tkeep;
    logic                        m_axis_tlast;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );
endinterface

// File: rtl/axis_tx_arbiter.sv
// Round-robin, packet-atomic arbiter feeding the single AXI-Stream TX input of
// the LBUS/AXIS converter from N_SRC sources.
// New grants are issued only while the link is aligned. Once a packet is locked,
// its beats pass through combinationally until its accepted tlast beat.
// Optional feature: define AXIS_ARB_PKT_CNT_EN to add o_pkt_cnt. This is a
// per-source, wrapping 32-bit count of accepted tlast beats.
module axis_tx_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DWIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_link_up,
    axis_tx_arbiter_if.slave      bus,
    output logic                  o_grant_valid,
    output logic [2:0]            o_grant_idx
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [N_SRC*32-1:0]   o_pkt_cnt
`endif
);

    localparam int         KW       = DWIDTH / 8;
    localparam logic [2:0] LAST_IDX = 3'(N_SRC - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t     r_state;
    logic [2:0] r_grant_idx;
    logic [2:0] r_last_grant;
    logic       r_grant_valid;

    logic       w_found;
    logic [2:0] w_next_idx;
    int         w_dist;
    int         w_best_dist;
    logic       w_last_beat;

    // Pick the first requester strictly after last_grant.
    // Each source's distance in the rotation is computed, and the nearest valid
    // source wins. Indices at or above N_SRC are never selected.
    always_comb begin
        w_found     = 1'b0;
        w_next_idx  = r_last_grant;
        w_dist      = 0;
        w_best_dist = N_SRC;
        for (int i = 0; i < N_SRC; i++) begin
            w_dist = (i + 2 * N_SRC - int'(r_last_grant) - 1) % N_SRC;
            if (bus.s_axis_tvalid[i] && (w_dist < w_best_dist)) begin
                w_found     = 1'b1;
                w_best_dist = w_dist;
                w_next_idx  = 3'(i);
            end
        end
    end

    // Zero-latency pass-through of the locked source.
    // While idle, every output and every ready is held low.
    always_comb begin
        bus.m_axis_tdata  = '0;
        bus.m_axis_tkeep  = '0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tvalid = 1'b0;
        bus.s_axis_tready = '0;
        if (r_state == ST_BUSY) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (r_grant_idx == 3'(i)) begin
                    bus.m_axis_tdata     = bus.s_axis_tdata[i*DWIDTH +: DWIDTH];
                    bus.m_axis_tkeep     = bus.s_axis_tkeep[i*KW +: KW];
                    bus.m_axis_tlast     = bus.s_axis_tlast[i];
                    bus.m_axis_tvalid    = bus.s_axis_tvalid[i];
                    bus.s_axis_tready[i] = bus.m_axis_tready;
                end
            end
        end
    end

    assign w_last_beat = bus.m_axis_tvalid & bus.m_axis_tready & bus.m_axis_tlast;

    // Packet lock FSM.
    // The link only gates the start of a packet. A locked packet runs to its
    // accepted tlast even if the link drops, and there is no timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= LAST_IDX;
            r_last_grant  <= LAST_IDX;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_link_up && w_found) begin
                        r_grant_idx   <= w_next_idx;
                        r_grant_valid <= 1'b1;
                        r_state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_last_beat) begin
                        r_last_grant  <= r_grant_idx;
                        r_grant_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant_valid = r_grant_valid;
    assign o_grant_idx   = r_grant_idx;

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [31:0] r_pkt_cnt [N_SRC];

    // Count completed packets per source; the natural 32-bit wrap is intended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_last_beat && (r_grant_idx == 3'(i))) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_cnt_out
        assign o_pkt_cnt[g*32 +: 32] = r_pkt_cnt[g];
    end
`endif

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed self-checking bench for axis_tx_arbiter with four sources.
// Each source is a small packet model. Every beat carries its source and beat
// number in tdata/tkeep. Accepted output beats are logged and compared against
// hand-written packet orders and cycle spacing.
module tb_axis_tx_arbiter;

   localparam int N_SRC  = 4;
   localparam int DWIDTH = 512;
   localparam int KW     = DWIDTH / 8;

   typedef struct {
      int         cyc;
      logic [7:0] src;
      logic [7:0] beat;
      logic       last;
      logic [7:0] top;
      logic [15:0] keep;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       linkUp;
   logic       grantValid;
   logic [2:0] grantIdx;
`ifdef AXIS_ARB_PKT_CNT_EN
   logic [N_SRC*32-1:0] pktCnt;
`endif

   axis_tx_arbiter_if #(.N_SRC(N_SRC), .DWIDTH(DWIDTH)) bus ();

   axis_tx_arbiter #(.N_SRC(N_SRC), .DWIDTH(DWIDTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_link_up     (linkUp),
      .bus           (bus),
      .o_grant_valid (grantValid),
      .o_grant_idx   (grantIdx)
`ifdef AXIS_ARB_PKT_CNT_EN
      ,
      .o_pkt_cnt     (pktCnt)
`endif
   );

   always #5 clk = ~clk;

   int    checkCount = 0;
   int    errCount   = 0;
   int    cycle      = 0;
   int    prevLast   = -1;
   int    prevCyc    = -1;
   int    violations = 0;
   int    busyCycles = 0;
   bit    toggleReady = 1'b0;
   int    pktsLeft [N_SRC];
   int    pktLen   [N_SRC];
   int    beatIdx  [N_SRC];
   beat_t beatLog[$];

   // Single comparison point: count it, and report a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present each source's current beat on the input bundle.
   task automatic driveSources();
      logic [DWIDTH-1:0] d;
      logic [KW-1:0]     k;
      for (int i = 0; i < N_SRC; i++) begin
         d = '0;
         k = '0;
         d[7:0]     = 8'(beatIdx[i]);
         d[15:8]    = 8'(i);
         d[DWIDTH-1 -: 8] = 8'h5A ^ 8'(i);
         k[7:0]     = 8'(beatIdx[i]);
         k[15:8]    = 8'hC0 | 8'(i);
         bus.s_axis_tdata[i*DWIDTH +: DWIDTH] = d;
         bus.s_axis_tkeep[i*KW +: KW]         = k;
         bus.s_axis_tvalid[i] = (pktsLeft[i] > 0);
         bus.s_axis_tlast[i]  = (pktsLeft[i] > 0) && (beatIdx[i] == pktLen[i] - 1);
      end
   endtask

   task automatic loadSource(input int s, input int n, input int len);
      pktsLeft[s] = n;
      pktLen[s]   = len;
      beatIdx[s]  = 0;
      driveSources();
   endtask

   task automatic clearSources();
      for (int i = 0; i < N_SRC; i++) begin
         pktsLeft[i] = 0;
         pktLen[i]   = 1;
         beatIdx[i]  = 0;
      end
      driveSources();
   endtask

   // One clock: sample at the falling edge, then advance the sources just after the rising edge.
   task automatic tick();
      logic [N_SRC-1:0] fire;
      logic [7:0]       dSrc;
      beat_t            e;
      @(negedge clk);
      cycle++;
      fire = bus.s_axis_tvalid & bus.s_axis_tready;
      if (grantValid) busyCycles++;
      if ($countones(fire) > 1) violations++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
         dSrc   = bus.m_axis_tdata[15:8];
         e.cyc  = cycle;
         e.src  = dSrc;
         e.beat = bus.m_axis_tdata[7:0];
         e.last = bus.m_axis_tlast;
         e.top  = bus.m_axis_tdata[DWIDTH-1 -: 8];
         e.keep = bus.m_axis_tkeep[15:0];
         beatLog.push_back(e);
         if (((fire >> dSrc) & 4'd1) == 4'd0) violations++;
      end else if (fire != '0) begin
         violations++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N_SRC; i++) begin
         if (fire[i]) begin
            if (beatIdx[i] == pktLen[i] - 1) begin
               beatIdx[i] = 0;
               pktsLeft[i]--;
            end else begin
               beatIdx[i]++;
            end
         end
      end
      if (toggleReady) bus.m_axis_tready = ~bus.m_axis_tready;
      driveSources();
   endtask

   // Run until n beats are logged or the cycle budget expires.
   task automatic applyStimulus(input string tag, input int n, input int budget);
      for (int c = 0; c < budget; c++) begin
         if (beatLog.size() >= n) break;
         tick();
      end
      checkOutput({tag, " beats"}, 64'(beatLog.size()), 64'(n));
   endtask

   // Pop one packet from the log and compare it beat by beat.
   task automatic checkPacket(input string tag, input int src, input int len,
                              input int gapExp, input bit contig);
      beat_t e;
      for (int b = 0; b < len; b++) begin
         if (beatLog.size() == 0) begin
            checkOutput({tag, " missing beat"}, 64'd0, 64'd1);
            return;
         end
         e = beatLog.pop_front();
         checkOutput({tag, " beat"},
                     {23'd0, e.src, e.beat, e.last, e.top, e.keep},
                     {23'd0, 8'(src), 8'(b), (b == len - 1), 8'h5A ^ 8'(src),
                      8'hC0 | 8'(src), 8'(b)});
         if (b == 0 && gapExp != 0 && prevLast >= 0)
            checkOutput({tag, " gap"}, 64'(e.cyc - prevLast), 64'(gapExp));
         if (b > 0 && contig)
            checkOutput({tag, " contiguous"}, 64'(e.cyc - prevCyc), 64'd1);
         prevCyc = e.cyc;
      end
      prevLast = prevCyc;
   endtask

   initial begin
      bit sawActivity;
      bit dropped;

      rst    = 1'b1;
      linkUp = 1'b0;
      bus.m_axis_tready = 1'b1;
      clearSources();
      repeat (2) @(posedge clk);
      #1;

      // Reset state.
      checkOutput("rst m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      checkOutput("rst m_tlast", 64'(bus.m_axis_tlast), 64'd0);
      checkOutput("rst m_tdata", 64'(|bus.m_axis_tdata), 64'd0);
      checkOutput("rst m_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
      checkOutput("rst s_tready", 64'(bus.s_axis_tready), 64'd0);
      checkOutput("rst grant_valid", 64'(grantValid), 64'd0);
      checkOutput("rst grant_idx", 64'(grantIdx), 64'd3);
      rst = 1'b0;

      // Link gating: everyone requests, link down for 20 cycles.
      for (int s = 0; s < N_SRC; s++) loadSource(s, 2, 3);
      sawActivity = 1'b0;
      repeat (20) begin
         tick();
         if (bus.m_axis_tvalid || grantValid || (bus.s_axis_tready != '0)) sawActivity = 1'b1;
      end
      checkOutput("gate activity", 64'(sawActivity), 64'd0);
      checkOutput("gate beats", 64'(beatLog.size()), 64'd0);
      linkUp = 1'b1;
      tick();
      checkOutput("link grant_valid", 64'(grantValid), 64'd1);
      checkOutput("link grant_idx", 64'(grantIdx), 64'd0);

      // Round robin: 0,1,2,3,0,1,2,3 with 3-beat packets and a one-cycle bubble.
      prevLast = -1;
      applyStimulus("rr", 24, 200);
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < N_SRC; s++)
            checkPacket("rr", s, 3, 2, 1);

      // Backpressure: source 2 locks alone, then sources 1 and 3 join.
      loadSource(2, 1, 8);
      for (int c = 0; c < 10; c++) begin
         tick();
         if (grantValid) break;
      end
      checkOutput("bp grant_idx", 64'(grantIdx), 64'd2);
      loadSource(1, 1, 3);
      loadSource(3, 1, 3);
      toggleReady = 1'b1;
      applyStimulus("bp", 14, 300);
      toggleReady = 1'b0;
      bus.m_axis_tready = 1'b1;
      checkPacket("bp src2", 2, 8, 0, 0);
      checkPacket("bp src3", 3, 3, 0, 0);
      checkPacket("bp src1", 1, 3, 0, 0);

      // Link drop during a 5-beat packet from source 2; source 3 waits.
      loadSource(2, 1, 5);
      loadSource(3, 1, 3);
      dropped = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (beatLog.size() >= 5) break;
         tick();
         if (!dropped && beatLog.size() >= 2) begin
            linkUp  = 1'b0;
            dropped = 1'b1;
         end
      end
      checkOutput("ld beats", 64'(beatLog.size()), 64'd5);
      sawActivity = 1'b0;
      repeat (10) begin
         tick();
         if (grantValid) sawActivity = 1'b1;
      end
      checkOutput("ld no grant", 64'(sawActivity), 64'd0);
      checkOutput("ld held beats", 64'(beatLog.size()), 64'd5);
      linkUp = 1'b1;
      applyStimulus("ld", 8, 100);
      checkPacket("ld src2", 2, 5, 0, 1);
      checkPacket("ld src3", 3, 3, 0, 1);

      // Reset in the middle of a packet from source 0.
      loadSource(0, 1, 5);
      applyStimulus("rm", 3, 50);
      beatLog.delete();
      rst = 1'b1;
      #1;
      checkOutput("rm m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      checkOutput("rm m_tdata", 64'(|bus.m_axis_tdata), 64'd0);
      checkOutput("rm s_tready", 64'(bus.s_axis_tready), 64'd0);
      checkOutput("rm grant_valid", 64'(grantValid), 64'd0);
      checkOutput("rm grant_idx", 64'(grantIdx), 64'd3);
      clearSources();
      loadSource(1, 1, 2);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (grantValid) break;
      end
      checkOutput("rm regrant idx", 64'(grantIdx), 64'd1);
      prevLast = -1;
      applyStimulus("rm", 2, 50);
      checkPacket("rm src1", 1, 2, 0, 1);

      // Single-beat packets: one busy cycle each, two cycles apart.
      busyCycles = 0;
      loadSource(0, 3, 1);
      prevLast = -1;
      applyStimulus("sb", 3, 50);
      repeat (2) tick();
      checkOutput("sb busy cycles", 64'(busyCycles), 64'd3);
      for (int p = 0; p < 3; p++) checkPacket("sb", 0, 1, 2, 1);

`ifdef AXIS_ARB_PKT_CNT_EN
      // Packet counters: ten packets from source 3, then a wrap from all ones.
      rst = 1'b1;
      clearSources();
      tick();
      rst = 1'b0;
      beatLog.delete();
      loadSource(3, 10, 1);
      applyStimulus("cnt", 10, 200);
      repeat (2) tick();
      checkOutput("cnt src0", 64'(pktCnt[0*32 +: 32]), 64'd0);
      checkOutput("cnt src1", 64'(pktCnt[1*32 +: 32]), 64'd0);
      checkOutput("cnt src2", 64'(pktCnt[2*32 +: 32]), 64'd0);
      checkOutput("cnt src3", 64'(pktCnt[3*32 +: 32]), 64'd10);
      force dut.r_pkt_cnt[3] = 32'hFFFF_FFFF;
      tick();
      release dut.r_pkt_cnt[3];
      checkOutput("cnt preload", 64'(pktCnt[3*32 +: 32]), 64'hFFFF_FFFF);
      beatLog.delete();
      loadSource(3, 1, 1);
      applyStimulus("wrap", 1, 50);
      repeat (2) tick();
      checkOutput("cnt wrap", 64'(pktCnt[3*32 +: 32]), 64'd0);
`endif

      checkOutput("handshake violations", 64'(violations), 64'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
